edge_detect: RTL and testbench



---
 rtl/edge_detect_if.sv | 11 +
 rtl/edge_detect.sv | 68 ++++++
 tb/tb_edge_detect.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/edge_detect_if.sv
// Interface bundling the USB D+ sample input and the edge pulse output.
interface edge_detect_if;
  logic d_plus;
  logic d_edge;

  // Driver of the line, consumer of the edge pulse (testbench / RX front end)
  modport master (output d_plus, input d_edge);

  // Edge detector side
  modport slave (input d_plus, output d_edge);
endinterface : edge_detect_if

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on every sampled transition of USB D+.
// The pulse feeds RX bit-sync so it can re-align its sampling phase.
// Optional build macro EDGE_DETECT_SYNC_EN inserts a 2-flop synchronizer
// ahead of the sample registers for an asynchronous D+ input.
module edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          n_rst,
  edge_detect_if.slave  bus
);

  logic samp_c;
  logic d_cur_q;
  logic d_cur_d;
  logic d_prev_q;
  logic d_prev_d;

`ifdef EDGE_DETECT_SYNC_EN
  logic s1_q;
  logic s1_d;
  logic s2_q;
  logic s2_d;

  // Synchronizer next-state: shift D+ through two stages
  always_comb begin
    s1_d = bus.d_plus;
    s2_d = s1_q;
  end

  // Synchronizer flops, held at the idle line level during reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_q <= RESET_LEVEL;
      s2_q <= RESET_LEVEL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign samp_c = s2_q;
`else
  // D+ is already synchronous to clk; sample it directly
  assign samp_c = bus.d_plus;
`endif

  // Sample pipeline next-state: current sample and the one before it
  always_comb begin
    d_cur_d  = samp_c;
    d_prev_d = d_cur_q;
  end

  // Sample registers; reset to idle so a non-idle line after release shows an edge
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      d_cur_q  <= RESET_LEVEL;
      d_prev_q <= RESET_LEVEL;
    end else begin
      d_cur_q  <= d_cur_d;
      d_prev_q <= d_prev_d;
    end
  end

  // Edge pulse derived only from flops; no combinational path from D+
  assign bus.d_edge = d_cur_q ^ d_prev_q;

endmodule : edge_detect

// File: tb/tb_edge_detect.sv
// Directed self-checking bench for edge_detect (default build; the
// synchronizer sequence runs when EDGE_DETECT_SYNC_EN is defined).
module tb_edge_detect;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  edge_detect_if bus_if ();

  edge_detect #(.RESET_LEVEL(1'b1)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst  = 1'b0;
    bus_if.d_plus = 1'b1;

`ifndef EDGE_DETECT_SYNC_EN
    // Reset with idle line for two edges
    step();
    step();
    check("rst_edge", bus_if.d_edge, 1'b0);
    check("rst_cur",  dut.d_cur_q,  1'b1);
    check("rst_prev", dut.d_prev_q, 1'b1);

    // Release with d_plus at reset level: no pulse
    n_rst = 1'b1;
    step();
    check("rel_idle", bus_if.d_edge, 1'b0);

    // Falling edge: one-cycle pulse
    bus_if.d_plus = 1'b0;
    step();
    check("fall_hi", bus_if.d_edge, 1'b1);
    step();
    check("fall_lo", bus_if.d_edge, 1'b0);
    step();
    check("fall_lo2", bus_if.d_edge, 1'b0);

    // Rising edge from stable 0: one-cycle pulse
    bus_if.d_plus = 1'b1;
    step();
    check("rise_hi", bus_if.d_edge, 1'b1);
    step();
    check("rise_lo", bus_if.d_edge, 1'b0);

    // Hold high for 5 cycles: no pulses
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_%0d", i), bus_if.d_edge, 1'b0);
    end

    // Toggle each cycle: continuous high, then back to 0
    bus_if.d_plus = 1'b0;
    step();
    check("tog_0", bus_if.d_edge, 1'b1);
    bus_if.d_plus = 1'b1;
    step();
    check("tog_1", bus_if.d_edge, 1'b1);
    bus_if.d_plus = 1'b0;
    step();
    check("tog_2", bus_if.d_edge, 1'b1);
    step();
    check("tog_end", bus_if.d_edge, 1'b0);

    // Sub-cycle glitch between edges is not sampled
    bus_if.d_plus = 1'b1;
    #2;
    bus_if.d_plus = 1'b0;
    step();
    check("glitch", bus_if.d_edge, 1'b0);

    // Reset mid-pulse clears the pulse at the next edge
    bus_if.d_plus = 1'b1;
    step();
    check("mid_hi", bus_if.d_edge, 1'b1);
    n_rst = 1'b0;
    bus_if.d_plus = 1'b0;
    step();
    check("mid_rst", bus_if.d_edge, 1'b0);
    check("mid_cur", dut.d_cur_q, 1'b1);

    // Reset coincident with a 1->0 transition: reset wins
    n_rst = 1'b1;
    bus_if.d_plus = 1'b1;
    step();
    check("pre_coin", bus_if.d_edge, 1'b0);
    n_rst = 1'b0;
    bus_if.d_plus = 1'b0;
    step();
    check("coin_rst", bus_if.d_edge, 1'b0);
    step();
    check("coin_rst2", bus_if.d_edge, 1'b0);

    // Release with d_plus != reset level: one pulse
    n_rst = 1'b1;
    step();
    check("rel_nonidle_hi", bus_if.d_edge, 1'b1);
    step();
    check("rel_nonidle_lo", bus_if.d_edge, 1'b0);
`else
    begin
      logic [7:0] exp_seq;
      logic [3:0] drv_seq;
      // d_plus after edges k..k+3 = 0,1,0,1 then held at 1; bit i = step i
      drv_seq = 4'b1010;
      exp_seq = 8'b0011_1100;

      step();
      step();
      check("s_rst_edge", bus_if.d_edge, 1'b0);
      check("s_rst_s1",   dut.s1_q,     1'b1);
      check("s_rst_s2",   dut.s2_q,     1'b1);
      n_rst = 1'b1;
      step();
      check("s_rel_idle", bus_if.d_edge, 1'b0);

      for (int i = 0; i < 8; i++) begin
        bus_if.d_plus = (i < 4) ? drv_seq[i] : 1'b1;
        step();
        check($sformatf("s_tog_%0d", i), bus_if.d_edge, exp_seq[i]);
      end

      // Reset with non-idle line, then release: pulse after 3 edges
      n_rst = 1'b0;
      bus_if.d_plus = 1'b0;
      step();
      check("s_rst2", bus_if.d_edge, 1'b0);
      n_rst = 1'b1;
      step();
      check("s_rel_0", bus_if.d_edge, 1'b0);
      step();
      check("s_rel_1", bus_if.d_edge, 1'b0);
      step();
      check("s_rel_2", bus_if.d_edge, 1'b1);
      step();
      check("s_rel_3", bus_if.d_edge, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_edge_detect
